lipsi_loader: RTL and testbench

- Program loader sitting directly upstream of the Lipsi core inside tt_um_schoeberl_lipsi.
- Receives a framed program image byte-by-byte from the dedicated input pins and writes it into the core's program/data memory write port.
- Holds the core in reset until a frame with a correct checksum has been stored, then releases it.
- Input pins are asynchronous to clk, so the loader synchronises them.

---
 rtl/lipsi_pkg.sv | 27 ++
 rtl/lipsi_pin_sync.sv | 52 +++++
 rtl/lipsi_loader.sv | 145 ++++++++++++++
 tb/tb_lipsi_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lipsi_pkg.sv
// -----------------------------------------------------------------------------
// lipsi_pkg
// Declarations shared by the Lipsi program loader and its pin synchroniser:
// the loader state encoding and the default frame/geometry constants.
// -----------------------------------------------------------------------------
package lipsi_pkg;

  // Default memory address width; an image holds up to 2**ADDR_W bytes.
  localparam int LIPSI_ADDR_W = 8;

  // Default frame start byte.
  localparam logic [7:0] LIPSI_HEADER = 8'hA5;

  // Default number of synchroniser flops on the input pins.
  localparam int LIPSI_SYNC_STAGES = 2;

  // Loader FSM states. RUN and ERR are terminal until reset.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

endpackage : lipsi_pkg

// File: rtl/lipsi_pin_sync.sv
// -----------------------------------------------------------------------------
// lipsi_pin_sync
// Brings the asynchronous byte strobe and data pins into the clk domain and
// turns each rising edge of the strobe into a single-cycle byte event.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   pin_data   in   [7:0] byte from the input pins (asynchronous)
//   pin_strobe in   byte strobe from the input pins (asynchronous)
//   byte_evt   out  one-cycle pulse per strobe rising edge
//   byte_val   out  [7:0] synchronised data, valid while byte_evt is high
// -----------------------------------------------------------------------------
module lipsi_pin_sync
  import lipsi_pkg::*;
#(
  parameter int SYNC_STAGES = LIPSI_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pin_data,
  input  logic       pin_strobe,
  output logic       byte_evt,
  output logic [7:0] byte_val
);

  // Data travels through the same number of stages as the strobe, so the
  // byte sampled with the event is the one the sender held around its edge.
  logic [SYNC_STAGES-1:0]      strobe_q;
  logic [SYNC_STAGES-1:0][7:0] data_q;
  logic                        strobe_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q      <= '0;
      data_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      strobe_q      <= {strobe_q[SYNC_STAGES-2:0], pin_strobe};
      data_q        <= {data_q[SYNC_STAGES-2:0], pin_data};
      strobe_prev_q <= strobe_q[SYNC_STAGES-1];
    end
  end

  // Edge detect on the last stage only: a strobe held high yields one event.
  assign byte_evt = strobe_q[SYNC_STAGES-1] & ~strobe_prev_q;
  assign byte_val = data_q[SYNC_STAGES-1];

endmodule : lipsi_pin_sync

// File: rtl/lipsi_loader.sv
// -----------------------------------------------------------------------------
// lipsi_loader
// Receives a framed program image (HEADER, LEN, LEN data bytes, CHK) from the
// input pins, writes the data bytes into the core memory from address 0, and
// releases the core once the 8-bit checksum of the data bytes matches CHK.
// LEN = 0 denotes a full 2**ADDR_W byte image.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   pin_data   in   [7:0] byte from the input pins (asynchronous)
//   pin_strobe in   byte strobe, rising edge marks one byte (asynchronous)
//   mem_addr   out  [ADDR_W-1:0] write address, holds when mem_we = 0
//   mem_wdata  out  [7:0] write data, holds when mem_we = 0
//   mem_we     out  one-cycle write pulse per data byte
//   cpu_run    out  releases the core from reset after a verified load
//   busy       out  frame reception in progress (LEN, DATA, CHK)
//   done       out  image loaded and verified (sticky until reset)
//   error      out  checksum mismatch (sticky until reset)
// -----------------------------------------------------------------------------
module lipsi_loader
  import lipsi_pkg::*;
#(
  parameter int         ADDR_W      = LIPSI_ADDR_W,
  parameter logic [7:0] HEADER      = LIPSI_HEADER,
  parameter int         SYNC_STAGES = LIPSI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pin_data,
  input  logic              pin_strobe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so the remaining count can hold a full 2**ADDR_W image.
  localparam int                CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(1);

  logic          byte_evt;
  logic [7:0]    byte_val;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [7:0]        sum_q;
  logic              busy_d, cpu_run_d, done_d, error_d;

  lipsi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk        (clk),
    .reset      (reset),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .byte_evt   (byte_evt),
    .byte_val   (byte_val)
  );

  // ---------------------------------------------------------------------------
  // State register, with the status outputs registered alongside it so they
  // change together with the state in the cycle after the deciding byte.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      cpu_run <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      cpu_run <= cpu_run_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A HEADER value seen after IDLE is ordinary payload.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves
  // state_d unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (byte_evt && byte_val == HEADER)   state_d = ST_LEN;
      ST_LEN:  if (byte_evt)                         state_d = ST_DATA;
      ST_DATA: if (byte_evt && remaining_q == LAST_COUNT) state_d = ST_CHK;
      ST_CHK:  if (byte_evt) state_d = (byte_val == sum_q) ? ST_RUN : ST_ERR;
      ST_RUN:  state_d = ST_RUN;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state; registered in the state register block.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d    = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_run_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_RUN);
    error_d   = (state_d == ST_ERR);
  end

  // ---------------------------------------------------------------------------
  // Datapath: length, address, checksum and the memory write port.
  // The address counter simply wraps after a full image; no write follows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (byte_evt) begin
        if (state_q == ST_LEN) begin
          remaining_q <= (byte_val == 8'h00) ? FULL_COUNT : CNT_W'(byte_val);
          addr_q      <= '0;
          sum_q       <= '0;
        end else if (state_q == ST_DATA) begin
          mem_we      <= 1'b1;
          mem_addr    <= addr_q;
          mem_wdata   <= byte_val;
          sum_q       <= sum_q + byte_val;
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
        end
      end
    end
  end

endmodule : lipsi_loader

// File: tb/tb_lipsi_loader.sv
// -----------------------------------------------------------------------------
// tb_lipsi_loader
// Self-checking bench for lipsi_loader. Frames come from a small table; the
// expected memory writes are queued as data bytes are sent and compared as
// mem_we pulses appear. Hand-written sequences cover the full-size image,
// a long strobe, and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_lipsi_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        pin_data;
  logic              pin_strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    string       name;
    int          n;           // bytes in frame
    logic [63:0] frame;       // byte 0 in bits 63:56
    int          first_data;  // index of first data byte
    int          n_writes;    // data bytes expected to be written
    logic        exp_run;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  lipsi_loader dut (
    .clk        (clk),
    .reset      (reset),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h we=%b, expected no write",
                 mem_addr, mem_wdata, mem_we);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (mem_we !== 1'b1 || mem_addr !== w.addr || mem_wdata !== w.data) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   mem_addr, mem_wdata, w.addr, w.data);
        end
      end
    end
  end

  // Data settles one cycle before the strobe rises; spacing keeps bytes well
  // above the minimum event distance.
  task automatic send_byte(input logic [7:0] b, input int hold = 2);
    @(negedge clk);
    pin_data = b;
    @(negedge clk);
    pin_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    pin_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_cpu_run"},   cpu_run,   0);
    check({tag, "_done"},      done,      0);
    check({tag, "_error"},     error,     0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero({tag, "_rst"});
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_end(input string tag, input logic exp_run, input logic exp_err);
    repeat (4) @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_cpu_run"}, cpu_run, exp_run);
    check({tag, "_done"},    done,    exp_run);
    check({tag, "_error"},   error,   exp_err);
    check({tag, "_busy"},    busy,    0);
  endtask

  initial begin
    reset      = 1'b1;
    pin_data   = 8'h00;
    pin_strobe = 1'b0;

    vecs[0] = '{"good", 6, 64'hA5_03_10_20_30_60_00_00, 2, 3, 1'b1, 1'b0};
    vecs[1] = '{"badchk", 6, 64'hA5_02_01_02_04_A5_00_00, 2, 2, 1'b0, 1'b1};
    vecs[2] = '{"junk", 7, 64'h00_FF_5A_A5_01_7F_7F_00, 5, 1, 1'b1, 1'b0};
    vecs[3] = '{"sumwrap", 5, 64'hA5_02_F0_20_10_00_00_00, 2, 2, 1'b1, 1'b0};

    // ---- table-driven frames ----
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].name);
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [7:0] b;
        b = vecs[v].frame[63 - 8*i -: 8];
        if (i >= vecs[v].first_data && i < vecs[v].first_data + vecs[v].n_writes)
          exp_q.push_back('{addr: ADDR_W'(i - vecs[v].first_data), data: b});
        send_byte(b);
        if (i == vecs[v].first_data)
          check({vecs[v].name, "_busy_mid"}, busy, 1);
      end
      check_end(vecs[v].name, vecs[v].exp_run, vecs[v].exp_err);
    end

    // ---- full 256-byte image, LEN = 0, checksum 0x80 ----
    do_reset("full");
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: 8'(i)});
      send_byte(8'(i));
    end
    check("full_busy_before_chk", busy, 1);
    check("full_last_addr", mem_addr, 8'hFF);
    check("full_last_data", mem_wdata, 8'hFF);
    send_byte(8'h80);
    check_end("full", 1'b1, 1'b0);

    // ---- strobe held high for 50 cycles on one data byte ----
    do_reset("hold");
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_q.push_back('{addr: 8'h00, data: 8'h33});
    send_byte(8'h33, 50);
    exp_q.push_back('{addr: 8'h01, data: 8'h44});
    send_byte(8'h44);
    send_byte(8'h77);
    check_end("hold", 1'b1, 1'b0);

    // ---- asynchronous reset after 2 of 4 data bytes ----
    do_reset("midrst");
    send_byte(8'hA5);
    send_byte(8'h04);
    exp_q.push_back('{addr: 8'h00, data: 8'h11});
    send_byte(8'h11);
    exp_q.push_back('{addr: 8'h01, data: 8'h22});
    send_byte(8'h22);
    check("midrst_busy_before", busy, 1);
    check("midrst_drained_before", exp_q.size(), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("midrst_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h01);
    exp_q.push_back('{addr: 8'h00, data: 8'h55});
    send_byte(8'h55);
    send_byte(8'h55);
    check_end("midrst_reload", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_lipsi_loader
